alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, handshaked successor to the combinational datapath ALU, parametrised in width.
- Adds shift ops, a multi-cycle shift-add multiply and a registered flag word (C/Z/N/V).
- Sits between the instruction decoder and register-file write-back.
- Accepts one operation at a time on a valid/ready input and holds each result until the consumer takes it.

Parameters:
- DATA_WIDTH, 8, operand/result width (>=2).
- OPCODE_WIDTH, 4, op_code width (>=4, so all alu_op_e codes fit).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  operation request
- o_ready  out  1  block can accept a request this cycle
- i_1  in  DATA_WIDTH  operand A
- i_2  in  DATA_WIDTH  operand B
- op_code  in  OPCODE_WIDTH  operation, alu_op_e encoding
- carry_in  in  1  carry/shift-in bit
- o_valid  out  1  result and flags valid
- i_res_ready  in  1  consumer accepts result
- o_main  out  DATA_WIDTH  result
- o_flags  out  4  {V,N,Z,C}

Behaviour:
- Reset values: o_main=0, o_flags=0, o_valid=0. State is IDLE, so o_ready=1 in the cycle after reset.
- Reset taken mid-operation aborts it, with no partial result emitted.
- States:
  - IDLE: o_ready=1.
  - MUL: o_ready=0.
  - HOLD: o_ready=0, o_valid=1.
- Acceptance: i_valid&&o_ready at an edge. Operands, op_code and carry_in are captured at that edge; later input changes are ignored. i_valid while o_ready=0 is ignored, not queued.
- Single-cycle ops: result and flags are registered at the accept edge, and the state goes to HOLD. o_valid is high from the next cycle (latency 1).
- ADD: {C,res} = i_1+i_2+carry_in.
- SUBTRACT: {C,res} = i_1+~i_2+carry_in (C = not-borrow; carry_in=1 gives a plain subtract).
- V for ADD/SUB: signed overflow of the operands as actually added.
- AND_OP/OR_OP/XOR_OP: bitwise. NOT_OP: ~i_1. All four give C=carry_in, V=0.
- SHL_OP: res={i_1[W-2:0],carry_in}, C=i_1[W-1], V=0.
- SHR_OP: res={carry_in,i_1[W-1:1]}, C=i_1[0], V=0.
- Any other code is LOAD: res=i_2, C=carry_in, V=0.
- Z=(res==0) and N=res[W-1] for all ops.
- MUL_OP (when compiled in):
  - At accept: load the shift-add engine, set step counter=0, go to MUL.
  - One step per cycle. On the DATA_WIDTH-th step, register res = low half of the product, C = |high half (truncation), V=0, then go to HOLD.
  - o_valid is high DATA_WIDTH cycles after the accept edge. carry_in is ignored.
- HOLD:
  - o_main/o_flags are stable.
  - On i_res_ready=1: next state IDLE, o_valid=0 next cycle. o_main/o_flags keep their last value.
  - Peak throughput is 1 op per 2 cycles.
  - i_res_ready outside HOLD is ignored.
- Counter wraps to 0 on completion. Operand registers are not cleared except by reset.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL_OP is executed by the alu_mul_seq engine; MUL state present.
- Undefined: no MUL state or engine is instantiated. MUL_OP is decoded as LOAD: 1-cycle, res=i_2, C=carry_in.

Decomposition:
- alu_pkg gains:
  - alu_op_e enum, sized to OPCODE_WIDTH=4: ADD=0, SUBTRACT=1, AND_OP=2, OR_OP=3, XOR_OP=4, NOT_OP=5, SHL_OP=6, SHR_OP=7, MUL_OP=8.
  - Flag index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
  - alu_state_e {IDLE, MUL, HOLD}.
- Sub-module alu_mul_seq (parametrised DATA_WIDTH):
  - Ports: start, a, b, busy, done, product[2*DATA_WIDTH-1:0].
  - Same clk/rst convention as alu_seq.
  - Instantiated only under ALU_SEQ_MUL_EN.

Test Plan:
- ADD 0xFF+0x01, carry_in=0 -> o_main=0x00, flags C=1 Z=1 N=0 V=0; o_valid 1 cycle after accept.
- SUBTRACT 0x80-0x01, carry_in=1 -> o_main=0x7F, C=1 V=1 N=0; SUBTRACT 0x00-0x01, carry_in=1 -> 0xFF, C=0 N=1.
- MUL 0x0F*0x11 -> 0xFF, C=0, o_valid exactly 8 cycles after accept; MUL 0x10*0x10 -> 0x00, C=1 Z=1. With macro undefined: MUL, i_2=0x11 -> 0x11 after 1 cycle.
- SHL 0x81, carry_in=1 -> 0x03 C=1; SHR 0x81, carry_in=0 -> 0x40 C=1.
- Backpressure: result held 5 cycles with i_res_ready=0 -> o_main/o_flags/o_valid stable, o_ready=0, new i_valid ignored; then i_res_ready=1 -> o_valid=0 and o_ready=1 next cycle.
- rst asserted 3 cycles into MUL -> next cycle o_valid=0, o_ready=1, o_main=0, o_flags=0; then LOAD op_code 0xF, i_2=0xA5, carry_in=1 -> 0xA5, C=1 N=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    SUBTRACT = 4'd1,
    AND_OP   = 4'd2,
    OR_OP    = 4'd3,
    XOR_OP   = 4'd4,
    NOT_OP   = 4'd5,
    SHL_OP   = 4'd6,
    SHR_OP   = 4'd7,
    MUL_OP   = 4'd8
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, DATA_WIDTH steps per start.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplr_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // product is the accumulator after the current step, so the final step's
  // result is visible combinationally alongside done.
  always_comb begin
    acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
  end

  assign done    = busy_q && (cnt_q == CW'(W - 1));
  assign busy    = busy_q;
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= {{W{1'b0}}, a};
      mplr_q  <= b;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with flags; multi-cycle MUL_OP only when ALU_SEQ_MUL_EN
// is defined, otherwise MUL_OP decodes as LOAD.
//
// state | meaning
// IDLE  | ready for a new operation
// MUL   | shift-add multiply in progress
// HOLD  | result valid, waiting for consumer
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_1,
  input  logic [DATA_WIDTH-1:0]   i_2,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic                    carry_in,
  output logic                    o_valid,
  input  logic                    i_res_ready,
  output logic [DATA_WIDTH-1:0]   o_main,
  output logic [3:0]              o_flags
);

  localparam int W = DATA_WIDTH;

  alu_state_e     state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [3:0]     flags_q, flags_d;
  logic [W-1:0]   b_eff;
  logic [W:0]     sum_c;
  logic [W-1:0]   res_c;
  logic           c_c;
  logic           v_c;
  logic           accept;

`ifdef ALU_SEQ_MUL_EN
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic           is_mul;

  assign is_mul    = (op_code == OPCODE_WIDTH'(MUL_OP));
  assign mul_start = accept && is_mul;
  assign o_ready   = (state_q == IDLE) && !mul_busy;

  alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (i_1),
    .b       (i_2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign o_ready = (state_q == IDLE);
`endif

  assign accept  = i_valid && o_ready;
  assign o_valid = (state_q == HOLD);
  assign o_main  = main_q;
  assign o_flags = flags_q;

  // Subtract is an add of the inverted operand, so V/C fall out of one adder.
  always_comb begin
    b_eff = (op_code == OPCODE_WIDTH'(SUBTRACT)) ? ~i_2 : i_2;
    sum_c = {1'b0, i_1} + {1'b0, b_eff} + {{W{1'b0}}, carry_in};
    res_c = i_2;
    c_c   = carry_in;
    v_c   = 1'b0;
    case (op_code)
      OPCODE_WIDTH'(ADD), OPCODE_WIDTH'(SUBTRACT): begin
        res_c = sum_c[W-1:0];
        c_c   = sum_c[W];
        v_c   = (i_1[W-1] == b_eff[W-1]) && (sum_c[W-1] != i_1[W-1]);
      end
      OPCODE_WIDTH'(AND_OP): res_c = i_1 & i_2;
      OPCODE_WIDTH'(OR_OP):  res_c = i_1 | i_2;
      OPCODE_WIDTH'(XOR_OP): res_c = i_1 ^ i_2;
      OPCODE_WIDTH'(NOT_OP): res_c = ~i_1;
      OPCODE_WIDTH'(SHL_OP): begin
        res_c = {i_1[W-2:0], carry_in};
        c_c   = i_1[W-1];
      end
      OPCODE_WIDTH'(SHR_OP): begin
        res_c = {carry_in, i_1[W-1:1]};
        c_c   = i_1[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (is_mul) begin
            state_d = MUL;
          end else
`endif
          begin
            main_d          = res_c;
            flags_d[FLAG_C] = c_c;
            flags_d[FLAG_Z] = (res_c == '0);
            flags_d[FLAG_N] = res_c[W-1];
            flags_d[FLAG_V] = v_c;
            state_d         = HOLD;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (mul_done) begin
          main_d          = mul_product[W-1:0];
          flags_d[FLAG_C] = |mul_product[2*W-1:W];
          flags_d[FLAG_Z] = (mul_product[W-1:0] == '0);
          flags_d[FLAG_N] = mul_product[W-1];
          flags_d[FLAG_V] = 1'b0;
          state_d         = HOLD;
        end
      end
`endif
      HOLD: begin
        if (i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      main_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against an arithmetic model.
module tb_alu_seq;

  localparam int W = 8;
  localparam int M = 255;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_1 = '0;
  logic [W-1:0] i_2 = '0;
  logic [3:0]   op_code = '0;
  logic         carry_in = 1'b0;
  logic         o_valid;
  logic         i_res_ready = 1'b0;
  logic [W-1:0] o_main;
  logic [3:0]   o_flags;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] obs_main;
  logic [3:0]   obs_flags;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(W), .OPCODE_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_1         (i_1),
    .i_2         (i_2),
    .op_code     (op_code),
    .carry_in    (carry_in),
    .o_valid     (o_valid),
    .i_res_ready (i_res_ready),
    .o_main      (o_main),
    .o_flags     (o_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: result, {V,N,Z,C} and cycles from accept to o_valid.
  function automatic void model(input int a, input int b, input int op, input int cin,
                                output int res, output int fl, output int lat);
    int s, c, v, sv;
    res = b; c = cin; v = 0; lat = 1;
    case (op)
      0: begin
        s = a + b + cin; res = s & M; c = (s >> 8) & 1;
        sv = sx(a) + sx(b) + cin; v = (sv > 127 || sv < -128) ? 1 : 0;
      end
      1: begin
        s = a + (M - b) + cin; res = s & M; c = (s >> 8) & 1;
        sv = sx(a) + sx(M - b) + cin; v = (sv > 127 || sv < -128) ? 1 : 0;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (~a) & M;
      6: begin res = ((a << 1) | cin) & M; c = (a >> 7) & 1; end
      7: begin res = (cin << 7) | (a >> 1); c = a & 1; end
      8: if (MUL_EN) begin
        s = a * b; res = s & M; c = (s > M) ? 1 : 0; v = 0; lat = W;
      end
      default: ;
    endcase
    fl = (v << 3) | ((res >= 128 ? 1 : 0) << 2) | ((res == 0 ? 1 : 0) << 1) | c;
  endfunction

  task automatic release_res(input string tag);
    @(negedge clk);
    i_res_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    chk({tag, "_main_kept"}, 32'(o_main), 32'(obs_main));
    i_res_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int op,
                        input int cin, input bit rel);
    int er, ef, el, lat;
    model(a, b, op, cin, er, ef, el);
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(o_ready), 32'd1);
    i_1 = 8'(a); i_2 = 8'(b); op_code = 4'(op); carry_in = 1'(cin);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_1      = 8'($urandom);
    i_2      = 8'($urandom);
    carry_in = 1'($urandom);
    op_code  = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (o_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_main"}, 32'(o_main), 32'(er));
    chk({tag, "_flags"}, 32'(o_flags), 32'(ef));
    chk({tag, "_ready_busy"}, 32'(o_ready), 32'd0);
    obs_main  = o_main;
    obs_flags = o_flags;
    if (rel) release_res(tag);
  endtask

  initial begin
    int seen;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_main", 32'(o_main), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);

    run_op("add_ff_01", 8'hFF, 8'h01, 0, 0, 1'b1);
    chk("add_const_main", 32'(obs_main), 32'h00);
    chk("add_const_flags", 32'(obs_flags), 32'b0011);
    run_op("sub_80_01", 8'h80, 8'h01, 1, 1, 1'b1);
    chk("sub_const_main", 32'(obs_main), 32'h7F);
    chk("sub_const_flags", 32'(obs_flags), 32'b1001);
    run_op("sub_00_01", 8'h00, 8'h01, 1, 1, 1'b1);
    chk("sub2_const_flags", 32'(obs_flags), 32'b0100);
    run_op("mul_0f_11", 8'h0F, 8'h11, 8, 0, 1'b1);
    run_op("mul_10_10", 8'h10, 8'h10, 8, 0, 1'b1);
    run_op("shl_81", 8'h81, 8'h00, 6, 1, 1'b1);
    chk("shl_const_main", 32'(obs_main), 32'h03);
    run_op("shr_81", 8'h81, 8'h00, 7, 0, 1'b1);
    chk("shr_const_main", 32'(obs_main), 32'h40);

    run_op("bp", 8'h3C, 8'h5A, 0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_main", 32'(o_main), 32'(obs_main));
      chk("bp_flags", 32'(o_flags), 32'(obs_flags));
      i_valid = 1'b1;
      op_code = 4'($urandom);
      i_1     = 8'($urandom);
      i_2     = 8'($urandom);
    end
    @(negedge clk);
    i_valid = 1'b0;
    release_res("bp");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_valid) seen = 1;
    end
    chk("bp_no_queue", 32'(seen), 32'd0);

    @(negedge clk);
    i_1 = 8'h0F; i_2 = 8'h11; op_code = 4'd8; carry_in = 1'b0;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_ready", 32'(o_ready), 32'd1);
    chk("mrst_main", 32'(o_main), 32'd0);
    chk("mrst_flags", 32'(o_flags), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (o_valid) seen = 1;
    end
    chk("mrst_no_result", 32'(seen), 32'd0);
    run_op("load_f", 8'h00, 8'hA5, 15, 1, 1'b1);
    chk("load_const_main", 32'(obs_main), 32'hA5);
    chk("load_const_flags", 32'(obs_flags), 32'b0101);

    for (int k = 0; k < 40; k++) begin
      run_op("rand", int'($urandom_range(0, M)), int'($urandom_range(0, M)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
